// File: rtl/bcd_convert_scheduler.sv
// bcd_convert_scheduler: one sequential double-dabble binary-to-BCD converter
// shared round-robin between a score requester and a timer requester.
// Each conversion takes N_BITS SHIFT cycles followed by a single DONE cycle.
// The result is written on the edge that enters DONE, and the owner's ack
// pulses high during the DONE cycle.
module bcd_convert_scheduler #(
    parameter int unsigned N_BITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_score,
    input  logic [N_BITS-1:0] score_bin,
    input  logic              req_timer,
    input  logic [N_BITS-1:0] timer_bin,
    output logic [11:0]       score_bcd,
    output logic [11:0]       timer_bcd,
    output logic              ack_score,
    output logic              ack_timer,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(N_BITS - 1);

    state_t            state_q;
    logic              owner_timer_q;   // 1: current conversion belongs to timer
    logic              prefer_timer_q;  // round-robin pointer, 0 favours score
    logic [N_BITS-1:0] shreg_q;
    logic [N_BITS-1:0] shreg_d;
    logic [11:0]       bcd_q;
    logic [11:0]       bcd_adj;
    logic [11:0]       bcd_d;
    logic [3:0]        cnt_q;
    logic [11:0]       score_bcd_q;
    logic [11:0]       timer_bcd_q;
    logic              ack_score_q;
    logic              ack_timer_q;
    logic              busy_q;
    logic              grant_timer;

    // Grant the timer when it is the only requester, or when both are
    // requesting and the pointer says it is the timer's turn.
    always_comb begin
        grant_timer = req_timer && (!req_score || prefer_timer_q);
    end

    // One double-dabble step: add 3 to each nibble >= 5, then shift
    // {BCD, operand} left by one with the operand MSB entering ones[0].
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_d   = (bcd_adj << 1) | 12'(shreg_q[N_BITS-1]);
        shreg_d = shreg_q << 1;
    end

    // Scheduler FSM, shared converter datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            owner_timer_q  <= 1'b0;
            prefer_timer_q <= 1'b0;
            shreg_q        <= '0;
            bcd_q          <= '0;
            cnt_q          <= '0;
            score_bcd_q    <= '0;
            timer_bcd_q    <= '0;
            ack_score_q    <= 1'b0;
            ack_timer_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            ack_score_q <= 1'b0;
            ack_timer_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_score || req_timer) begin
                        owner_timer_q  <= grant_timer;
                        prefer_timer_q <= !grant_timer;
                        shreg_q        <= grant_timer ? timer_bin : score_bin;
                        bcd_q          <= '0;
                        cnt_q          <= '0;
                        busy_q         <= 1'b1;
                        state_q        <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q   <= bcd_d;
                    shreg_q <= shreg_d;
                    cnt_q   <= cnt_q + 4'd1;
                    // The final step's result goes straight to the owner's
                    // register on the same edge that enters DONE.
                    if (cnt_q == LAST_CNT) begin
                        state_q <= DONE;
                        if (owner_timer_q) begin
                            timer_bcd_q <= bcd_d;
                            ack_timer_q <= 1'b1;
                        end else begin
                            score_bcd_q <= bcd_d;
                            ack_score_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign score_bcd = score_bcd_q;
    assign timer_bcd = timer_bcd_q;
    assign ack_score = ack_score_q;
    assign ack_timer = ack_timer_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// Directed testbench for bcd_convert_scheduler (N_BITS = 8).
module tb_bcd_convert_scheduler;

    logic        clk;
    logic        rst_n;
    logic        req_score;
    logic [7:0]  score_bin;
    logic        req_timer;
    logic [7:0]  timer_bin;
    logic [11:0] score_bcd;
    logic [11:0] timer_bcd;
    logic        ack_score;
    logic        ack_timer;
    logic        busy;

    int unsigned n_vec;
    int unsigned n_err;
    logic [11:0] exp_score;
    logic [11:0] exp_timer;

    bcd_convert_scheduler #(.N_BITS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_score (req_score),
        .score_bin (score_bin),
        .req_timer (req_timer),
        .timer_bin (timer_bin),
        .score_bcd (score_bcd),
        .timer_bcd (timer_bcd),
        .ack_score (ack_score),
        .ack_timer (ack_timer),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Acks must never overlap.
    always @(negedge clk) begin
        if (ack_score && ack_timer) check("ack_overlap", 32'd1, 32'd0);
    end

    // Called at a negedge while the DUT is in IDLE; returns at a negedge in IDLE.
    task automatic run_one(input bit tmr, input int val, input string tag);
        int unsigned lat;
        int unsigned busy_cnt;
        logic [1:0]  ack_seen;
        lat      = 0;
        busy_cnt = 0;
        ack_seen = 2'b00;
        if (tmr) begin
            req_timer = 1'b1;
            timer_bin = 8'(val);
        end else begin
            req_score = 1'b1;
            score_bin = 8'(val);
        end
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (ack_score || ack_timer) begin
                lat      = c;
                ack_seen = {ack_score, ack_timer};
            end
            // Operands changing after the grant edge must not matter.
            if (c == 1) begin
                score_bin = ~8'(val);
                timer_bin = ~8'(val);
            end
        end
        req_score = 1'b0;
        req_timer = 1'b0;
        if (tmr) exp_timer = to_bcd(val);
        else     exp_score = to_bcd(val);
        check($sformatf("%s_lat", tag), lat, 32'd9);
        check($sformatf("%s_ack", tag), 32'(ack_seen), tmr ? 32'd1 : 32'd2);
        check($sformatf("%s_busy", tag), busy_cnt, 32'd9);
        check($sformatf("%s_score", tag), 32'(score_bcd), 32'(exp_score));
        check($sformatf("%s_timer", tag), 32'(timer_bcd), 32'(exp_timer));
        @(negedge clk);
        check($sformatf("%s_idle", tag), 32'({busy, ack_score, ack_timer}), 32'd0);
    endtask

    initial begin
        logic [1:0]  order [4];
        int unsigned n_ack;
        int unsigned gap;
        bit          stray;
        n_vec     = 0;
        n_err     = 0;
        exp_score = 12'h000;
        exp_timer = 12'h000;
        rst_n     = 1'b0;
        req_score = 1'b0;
        req_timer = 1'b0;
        score_bin = 8'd0;
        timer_bin = 8'd0;

        // Reset values, asserted before any clock edge.
        #1;
        check("rst_outs", 32'({score_bcd, timer_bcd, ack_score, ack_timer, busy}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single conversions.
        run_one(1'b0, 255, "s255");
        run_one(1'b1, 0,   "t0");
        run_one(1'b1, 99,  "t99");
        run_one(1'b1, 100, "t100");

        // Both requesting from reset: score first, one idle cycle, then timer.
        rst_n     = 1'b0;
        exp_score = 12'h000;
        exp_timer = 12'h000;
        req_score = 1'b1;
        req_timer = 1'b1;
        score_bin = 8'd42;
        timer_bin = 8'd7;
        @(negedge clk);
        rst_n = 1'b1;
        n_ack = 0;
        gap   = 0;
        for (int c = 0; c < 40 && n_ack < 2; c++) begin
            @(negedge clk);
            if (n_ack == 1 && !busy) gap++;
            if (ack_score || ack_timer) begin
                order[n_ack] = {ack_score, ack_timer};
                n_ack++;
                if (n_ack == 1) begin
                    check("both_first_bcd", 32'(score_bcd), 32'h042);
                    req_score = 1'b0;
                end else begin
                    check("both_second_bcd", 32'(timer_bcd), 32'h007);
                    req_timer = 1'b0;
                end
            end
        end
        check("both_n_ack", n_ack, 32'd2);
        check("both_first", 32'(order[0]), 32'd2);
        check("both_second", 32'(order[1]), 32'd1);
        check("both_gap", gap, 32'd1);
        exp_score = 12'h042;
        exp_timer = 12'h007;
        @(negedge clk);

        // Both held permanently high: strict alternation.
        req_score = 1'b1;
        req_timer = 1'b1;
        n_ack = 0;
        for (int c = 0; c < 60 && n_ack < 4; c++) begin
            @(negedge clk);
            if (ack_score || ack_timer) begin
                order[n_ack] = {ack_score, ack_timer};
                n_ack++;
            end
        end
        req_score = 1'b0;
        req_timer = 1'b0;
        check("rr_n_ack", n_ack, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_ack%0d", i), 32'(order[i]), (i % 2 == 0) ? 32'd2 : 32'd1);
        end
        check("rr_score", 32'(score_bcd), 32'h042);
        check("rr_timer", 32'(timer_bcd), 32'h007);
        @(negedge clk);

        // Reset during the 4th SHIFT cycle of score 200 aborts the conversion.
        req_score = 1'b1;
        score_bin = 8'd200;
        for (int c = 1; c <= 4; c++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ack", 32'({ack_score, ack_timer}), 32'd0);
        check("abort_score", 32'(score_bcd), 32'h000);
        check("abort_timer", 32'(timer_bcd), 32'h000);
        exp_score = 12'h000;
        exp_timer = 12'h000;
        req_score = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ack_score || ack_timer || busy) stray = 1'b1;
        end
        check("abort_quiet", 32'(stray), 32'd0);
        check("abort_score_hold", 32'(score_bcd), 32'h000);

        // Exhaustive sweep on both requesters.
        for (int v = 0; v < 256; v++) begin
            run_one(1'b0, v, $sformatf("sw_s%0d", v));
            run_one(1'b1, v, $sformatf("sw_t%0d", v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_convert_scheduler.md
BCD_CONVERT_SCHEDULER -- requirements
Module: bcd_convert_scheduler

Interface
REQ-001 Parameter: N_BITS, default 8, binary operand width; legal range 4..8.
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req_score  input  1  score requester asks for conversion; level, held until ack_score.
REQ-005 Port: score_bin  input  N_BITS  score operand; sampled only at the score grant edge.
REQ-006 Port: req_timer  input  1  timer requester asks for conversion; level, held until ack_timer.
REQ-007 Port: timer_bin  input  N_BITS  timer operand; sampled only at the timer grant edge.
REQ-008 Port: score_bcd  output  12  registered {hundreds, tens, ones} BCD of last score conversion.
REQ-009 Port: timer_bcd  output  12  registered {hundreds, tens, ones} BCD of last timer conversion.
REQ-010 Port: ack_score  output  1  one-cycle pulse; score_bcd updated on the same edge.
REQ-011 Port: ack_timer  output  1  one-cycle pulse; timer_bcd updated on the same edge.
REQ-012 Port: busy  output  1  high in every state except IDLE.

Function
REQ-013 Block SHALL time-share one sequential double-dabble converter between the score and timer requesters.
REQ-014 FSM states SHALL be IDLE, SHIFT and DONE; IDLE is the reset state.
REQ-015 In IDLE with at least one request high, next edge SHALL grant one requester, load its operand into the shift register, clear the 12-bit BCD accumulator and bit counter, and go to SHIFT.
REQ-016 Only one requester high: that requester SHALL be granted.
REQ-017 Both requesters high: grant SHALL go to the requester not granted last (round-robin pointer); after reset the pointer SHALL favour score.
REQ-018 Each SHIFT cycle SHALL add 3 to every BCD nibble >= 5, then shift {BCD, operand} left by one with the operand MSB entering ones[0].
REQ-019 SHIFT SHALL last exactly N_BITS cycles, then go to DONE.
REQ-020 On the DONE entry edge the accumulator SHALL be written to the granted owner's output register only; the other register SHALL hold.
REQ-021 In DONE the granted owner's ack SHALL be high for exactly one cycle; the next edge SHALL return to IDLE.
REQ-022 Latency SHALL be N_BITS+1 cycles from grant edge to ack-high cycle; a single request completes in N_BITS+2 cycles from request-visible IDLE cycle to ack.
REQ-023 Requests arriving during SHIFT or DONE SHALL be ignored until IDLE; operand changes after the grant edge SHALL not affect the result.
REQ-024 A requester still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-025 ack_score and ack_timer SHALL never be high in the same cycle.
REQ-026 Results SHALL be exact for every operand 0..2^N_BITS-1; hundreds nibble SHALL never exceed 2.

Reset
REQ-027 While rst_n is low, regardless of clk: state = IDLE, score_bcd = 12'h000, timer_bcd = 12'h000, ack_score = 0, ack_timer = 0, busy = 0, round-robin pointer = favour score.
REQ-028 Reset asserted mid-SHIFT or in DONE SHALL abort the conversion with no ack and no result-register write.
REQ-029 After rst_n deasserts, the first grant SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-030 req_score=1, score_bin=8'd255 -> ack_score 9 cycles after grant edge, score_bcd=12'h255, timer_bcd stays 12'h000.
REQ-031 req_timer=1, timer_bin=8'd0, then 8'd99, then 8'd100 -> timer_bcd = 12'h000, 12'h099, 12'h100 in turn.
REQ-032 req_score and req_timer both high from reset, score 8'd42, timer 8'd7 -> score served first (12'h042), timer second (12'h007); busy low for exactly 1 cycle between the two conversions.
REQ-033 Both requesters held permanently high -> acks alternate score, timer, score, timer.
REQ-034 rst_n pulsed low during the 4th SHIFT cycle of score 8'd200 -> no ack_score, score_bcd=12'h000, busy=0 immediately.
REQ-035 Exhaustive sweep 0..255 on each requester -> every result matches the decimal value; busy high exactly 9 cycles per conversion.
